// File: rtl/snn_input_pkg.sv
// rtl/snn_input_pkg.sv - shared defaults, pointer types and helpers for the SNN input value buffer
package snn_input_pkg;

    localparam int DATA_W_DEF    = 8;
    localparam int DEPTH_DEF     = 1023;
    localparam int NUM_BANKS_DEF = 2;
    localparam int DROP_CNT_W    = 16;

    // Ring pointer wide enough for up to 4 banks; occupancy counter counts 0..4.
    typedef logic [1:0] bank_ptr_t;
    typedef logic [2:0] bank_cnt_t;

    // Advance a ring pointer, wrapping after the last bank in use.
    function automatic bank_ptr_t next_ptr(input bank_ptr_t p, input int nb);
        return (int'(p) == nb - 1) ? '0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/input_value_bank.sv
// rtl/input_value_bank.sv - one simple dual-port value RAM with a registered read port
module input_value_bank
    import snn_input_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port plus registered read port; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/input_value_buffer.sv
// rtl/input_value_buffer.sv - multi-bank ring input value buffer; optional drop counter via INPUT_BUF_DROP_CNT_EN
module input_value_buffer
    import snn_input_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int NUM_BANKS = NUM_BANKS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    input  logic              rd_done,
    output logic              sample_ready
`ifdef INPUT_BUF_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam bank_cnt_t       FULL    = bank_cnt_t'(NUM_BANKS);
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    bank_ptr_t         wr_ptr;
    bank_ptr_t         rd_ptr;
    bank_cnt_t         full_cnt;
    bank_ptr_t         rd_sel_q;
    logic              rd_zero_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] hold_q;
    logic [DATA_W-1:0] bank_q [NUM_BANKS];
    logic [DATA_W-1:0] bank_mux;

    logic wr_addr_ok, rd_addr_ok;
    logic wr_accept, commit, release_bank, rd_accept;

    assign wr_ready     = (full_cnt < FULL);
    assign sample_ready = (full_cnt != '0);
    assign wr_addr_ok   = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_addr_ok   = ({1'b0, rd_addr} < DEPTH_L);
    assign wr_accept    = wr_en && wr_ready && wr_addr_ok;
    assign commit       = wr_en && wr_last && wr_ready;
    assign release_bank = rd_done && sample_ready;
    assign rd_accept    = rd_en && sample_ready;

    // Ring pointers and occupancy; simultaneous commit and release leave the count unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            full_cnt <= '0;
        end else begin
            if (commit) begin
                wr_ptr <= next_ptr(wr_ptr, NUM_BANKS);
            end
            if (release_bank) begin
                rd_ptr <= next_ptr(rd_ptr, NUM_BANKS);
            end
            case ({commit, release_bank})
                2'b10:   full_cnt <= full_cnt + 3'd1;
                2'b01:   full_cnt <= full_cnt - 3'd1;
                default: full_cnt <= full_cnt;
            endcase
        end
    end

    // Read pipeline: remember which bank answered (pre-release pointer) and whether the address was out of range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_sel_q   <= '0;
            rd_zero_q  <= 1'b0;
            hold_q     <= '0;
        end else begin
            rd_valid_q <= rd_accept;
            if (rd_accept) begin
                rd_sel_q  <= rd_ptr;
                rd_zero_q <= !rd_addr_ok;
            end
            if (rd_valid_q) begin
                hold_q <= rd_data;
            end
        end
    end

    // Select the answering bank; rd_data holds the last result between reads.
    always_comb begin
        bank_mux = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (rd_sel_q == bank_ptr_t'(i)) begin
                bank_mux = bank_q[i];
            end
        end
    end

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_valid_q ? (rd_zero_q ? '0 : bank_mux) : hold_q;

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        input_value_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk     (clk),
            .wr_en   (wr_accept && (wr_ptr == bank_ptr_t'(g))),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_en   (rd_accept && rd_addr_ok && (rd_ptr == bank_ptr_t'(g))),
            .rd_addr (rd_addr),
            .rd_data (bank_q[g])
        );
    end

`ifdef INPUT_BUF_DROP_CNT_EN
    logic dropped;
    assign dropped = wr_en && !(wr_ready && wr_addr_ok);

    // Saturating count of writes that never reached memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt <= '0;
        end else if (dropped && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_input_value_buffer.sv
// tb/tb_input_value_buffer.sv - self-checking bench for input_value_buffer against a behavioural bank model
module tb_input_value_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 1023;
    localparam int AW    = 10;
    localparam int NB    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_last = 1'b0;
    logic          wr_ready;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          rd_done = 1'b0;
    logic          sample_ready;
`ifdef INPUT_BUF_DROP_CNT_EN
    logic [15:0]   drop_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    // Model: contents per bank, a FIFO of committed banks, the bank being filled.
    logic [7:0] m_mem   [NB][DEPTH];
    bit         m_known [NB][DEPTH];
    int         m_committed [$];
    int         m_wb;
    int         m_drops;
    logic [7:0] e_data;
    logic       e_valid;
    bit         e_known;

    input_value_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .wr_last      (wr_last),
        .wr_ready     (wr_ready),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_done      (rd_done),
        .sample_ready (sample_ready)
`ifdef INPUT_BUF_DROP_CNT_EN
        ,
        .drop_cnt     (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic bit m_wr_ready();
        return m_committed.size() < NB;
    endfunction

    function automatic bit m_sample_ready();
        return m_committed.size() != 0;
    endfunction

    task automatic model_reset();
        m_committed.delete();
        m_wb    = 0;
        m_drops = 0;
        e_data  = 8'h00;
        e_valid = 1'b0;
        e_known = 1'b1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // One clock: drive inputs, update the model from pre-edge state, settle 1ns past the edge.
    task automatic step(input bit we, input int wa, input logic [7:0] wd, input bit wl,
                        input bit re, input int ra, input bit rdn);
        bit wrdy, srdy;
        int rb;
        wr_en   = we;
        wr_addr = wa[AW-1:0];
        wr_data = wd;
        wr_last = wl;
        rd_en   = re;
        rd_addr = ra[AW-1:0];
        rd_done = rdn;
        @(posedge clk);
        wrdy = m_wr_ready();
        srdy = m_sample_ready();
        rb   = srdy ? m_committed[0] : 0;
        if (we) begin
            if (wrdy && wa < DEPTH) begin
                m_mem[m_wb][wa]   = wd;
                m_known[m_wb][wa] = 1'b1;
            end else if (m_drops < 65535) begin
                m_drops++;
            end
        end
        if (re && srdy) begin
            e_valid = 1'b1;
            if (ra >= DEPTH) begin
                e_data  = 8'h00;
                e_known = 1'b1;
            end else begin
                e_data  = m_mem[rb][ra];
                e_known = m_known[rb][ra];
            end
        end else begin
            e_valid = 1'b0;
        end
        if (rdn && srdy) begin
            void'(m_committed.pop_front());
        end
        if (we && wl && wrdy) begin
            m_committed.push_back(m_wb);
            m_wb = (m_wb + 1) % NB;
        end
        #1;
        wr_en   = 1'b0;
        wr_last = 1'b0;
        rd_en   = 1'b0;
        rd_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #2;
        n_cmp++; if (wr_ready !== 1'b1)     begin n_fail++; $display("FAIL reset_wr_ready got %b want 1", wr_ready); end
        n_cmp++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL reset_sample_ready got %b want 0", sample_ready); end
        n_cmp++; if (rd_valid !== 1'b0)     begin n_fail++; $display("FAIL reset_rd_valid got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 8'h00)     begin n_fail++; $display("FAIL reset_rd_data got %h want 00", rd_data); end
`ifdef INPUT_BUF_DROP_CNT_EN
        n_cmp++; if (drop_cnt !== 16'h0)    begin n_fail++; $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); end
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_fill_read();
        for (int a = 0; a < DEPTH; a++) begin
            step(1, a, a[7:0], a == DEPTH - 1, 0, 0, 0);
        end
        n_cmp++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL fill_sample_ready got %b want 1", sample_ready); end
        n_cmp++; if (wr_ready !== 1'b1)     begin n_fail++; $display("FAIL fill_wr_ready got %b want 1", wr_ready); end
        step(0, 0, 0, 0, 1, 5, 0);
        n_cmp++; if (rd_valid !== 1'b1)     begin n_fail++; $display("FAIL fill_rd_valid got %b want 1", rd_valid); end
        n_cmp++; if (rd_data !== 8'd5)      begin n_fail++; $display("FAIL fill_rd_data got %h want 05", rd_data); end
        step(0, 0, 0, 0, 0, 0, 0);
        n_cmp++; if (rd_valid !== 1'b0)     begin n_fail++; $display("FAIL fill_rd_valid_pulse got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 8'd5)      begin n_fail++; $display("FAIL fill_rd_data_hold got %h want 05", rd_data); end
    endtask

    task automatic test_overlap();
        int ra;
        for (int a = 0; a < DEPTH; a++) begin
            ra = $urandom_range(0, DEPTH - 1);
            step(1, a, 8'($urandom), a == DEPTH - 1, $urandom_range(0, 1), ra, 0);
            n_cmp++; if (rd_valid !== e_valid) begin n_fail++; $display("FAIL overlap_rd_valid addr %0d got %b want %b", ra, rd_valid, e_valid); end
            if (e_valid) begin
                n_cmp++; if (rd_data !== ra[7:0]) begin n_fail++; $display("FAIL overlap_rd_data addr %0d got %h want %h", ra, rd_data, ra[7:0]); end
            end
        end
        n_cmp++; if (wr_ready !== 1'b0)     begin n_fail++; $display("FAIL overlap_wr_ready got %b want 0", wr_ready); end
        n_cmp++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL overlap_sample_ready got %b want 1", sample_ready); end
        for (int k = 0; k < 3; k++) begin
            ra = $urandom_range(0, 40);
            step(1, ra, 8'hEE, 0, 1, ra, 0);
            n_cmp++; if (rd_data !== ra[7:0]) begin n_fail++; $display("FAIL overlap_after_drop addr %0d got %h want %h", ra, rd_data, ra[7:0]); end
`ifdef INPUT_BUF_DROP_CNT_EN
            n_cmp++; if (drop_cnt !== 16'(k + 1)) begin n_fail++; $display("FAIL overlap_drop_cnt got %0d want %0d", drop_cnt, k + 1); end
`endif
        end
    endtask

    task automatic test_commit_release();
        apply_reset();
        for (int a = 0; a < 8; a++) step(1, a, 8'h10 + 8'(a), a == 7, 0, 0, 0);
        for (int a = 0; a < 7; a++) step(1, a, 8'h50 + 8'(a), 0, 0, 0, 0);
        step(1, 7, 8'h57, 1, 0, 0, 1);
        n_cmp++; if (wr_ready !== 1'b1)     begin n_fail++; $display("FAIL cr_wr_ready got %b want 1", wr_ready); end
        n_cmp++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL cr_sample_ready got %b want 1", sample_ready); end
        step(0, 0, 0, 0, 1, 3, 0);
        n_cmp++; if (rd_data !== 8'h53)     begin n_fail++; $display("FAIL cr_read_bank1 got %h want 53", rd_data); end
        for (int a = 0; a < 8; a++) step(1, a, 8'hA0 + 8'(a), a == 7, 0, 0, 0);
        n_cmp++; if (wr_ready !== 1'b0)     begin n_fail++; $display("FAIL cr_second_commit_full got %b want 0", wr_ready); end
    endtask

    task automatic test_read_and_done();
        step(0, 0, 0, 0, 1, 3, 1);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h53) begin n_fail++; $display("FAIL rdd_same_cycle got %b/%h want 1/53", rd_valid, rd_data); end
        step(0, 0, 0, 0, 1, 3, 0);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'hA3) begin n_fail++; $display("FAIL rdd_next_bank got %b/%h want 1/a3", rd_valid, rd_data); end
        n_cmp++; if (wr_ready !== 1'b1)     begin n_fail++; $display("FAIL rdd_wr_ready got %b want 1", wr_ready); end
    endtask

    task automatic test_oor();
        step(0, 0, 0, 0, 1, 6, 1);
        n_cmp++; if (rd_data !== 8'hA6)     begin n_fail++; $display("FAIL oor_last_read got %h want a6", rd_data); end
        n_cmp++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL oor_empty got %b want 0", sample_ready); end
        step(0, 0, 0, 0, 1, 2, 0);
        n_cmp++; if (rd_valid !== 1'b0)     begin n_fail++; $display("FAIL oor_empty_rd_valid got %b want 0", rd_valid); end
        n_cmp++; if (rd_data !== 8'hA6)     begin n_fail++; $display("FAIL oor_empty_rd_hold got %h want a6", rd_data); end
        step(1, 1023, 8'h77, 1, 0, 0, 0);
        n_cmp++; if (sample_ready !== 1'b1) begin n_fail++; $display("FAIL oor_drop_commits got %b want 1", sample_ready); end
`ifdef INPUT_BUF_DROP_CNT_EN
        n_cmp++; if (drop_cnt !== 16'(m_drops)) begin n_fail++; $display("FAIL oor_drop_cnt got %0d want %0d", drop_cnt, m_drops); end
`endif
        step(0, 0, 0, 0, 1, 1023, 0);
        n_cmp++; if (rd_valid !== 1'b1 || rd_data !== 8'h00) begin n_fail++; $display("FAIL oor_read_zero got %b/%h want 1/00", rd_valid, rd_data); end
    endtask

    task automatic test_reset_mid();
        step(1, 0, 8'h33, 1, 0, 0, 0);
        n_cmp++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL mid_two_committed got %b want 0", wr_ready); end
        step(0, 0, 0, 0, 1, 0, 0);
        n_cmp++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL mid_inflight got %b want 1", rd_valid); end
        rst = 1'b1;
        model_reset();
        #1;
        n_cmp++; if (rd_valid !== 1'b0)     begin n_fail++; $display("FAIL mid_rd_valid got %b want 0", rd_valid); end
        n_cmp++; if (sample_ready !== 1'b0) begin n_fail++; $display("FAIL mid_sample_ready got %b want 0", sample_ready); end
        n_cmp++; if (wr_ready !== 1'b1)     begin n_fail++; $display("FAIL mid_wr_ready got %b want 1", wr_ready); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_random();
        int wa, ra;
        for (int c = 0; c < 3000; c++) begin
            wa = ($urandom_range(0, 15) == 0) ? 1023 : $urandom_range(0, 15);
            ra = ($urandom_range(0, 15) == 0) ? 1023 : $urandom_range(0, 15);
            step($urandom_range(0, 1), wa, 8'($urandom), $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1), ra, $urandom_range(0, 11) == 0);
            n_cmp++; if (wr_ready !== m_wr_ready())         begin n_fail++; $display("FAIL rnd_wr_ready cyc %0d got %b want %b", c, wr_ready, m_wr_ready()); end
            n_cmp++; if (sample_ready !== m_sample_ready()) begin n_fail++; $display("FAIL rnd_sample_ready cyc %0d got %b want %b", c, sample_ready, m_sample_ready()); end
            n_cmp++; if (rd_valid !== e_valid)              begin n_fail++; $display("FAIL rnd_rd_valid cyc %0d got %b want %b", c, rd_valid, e_valid); end
            if (e_known) begin
                n_cmp++; if (rd_data !== e_data) begin n_fail++; $display("FAIL rnd_rd_data cyc %0d got %h want %h", c, rd_data, e_data); end
            end
        end
`ifdef INPUT_BUF_DROP_CNT_EN
        n_cmp++; if (drop_cnt !== 16'(m_drops)) begin n_fail++; $display("FAIL rnd_drop_cnt got %0d want %0d", drop_cnt, m_drops); end
`endif
    endtask

    initial begin
        test_reset();
        test_fill_read();
        test_overlap();
        test_commit_release();
        test_read_and_done();
        test_oor();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/input_value_buffer.md
# input_value_buffer

Parametrised multi-bank (ring) input value memory for the bin-ratio ensemble SNN. The loader writes one sample's per-input-neuron values (spike counts) into a free bank while the SNN core reads the previous sample from a committed bank, so loading and inference overlap. Bank hand-over uses explicit commit (`wr_last`) and release (`rd_done`) handshakes. Sits between the sample loader and the input-neuron spike generator.

## Interface
- `DATA_W`, 8, width of one stored input value
- `DEPTH`, 1023, entries per bank (input neuron count)
- `ADDR_W`, `$clog2(DEPTH)` (10), address width
- `NUM_BANKS`, 2, banks in the ring (1..4)
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `wr_en`  in  1  write strobe
- `wr_addr`  in  ADDR_W  write address within current write bank
- `wr_data`  in  DATA_W  write data
- `wr_last`  in  1  qualified by `wr_en`; this write completes the sample and commits the bank
- `wr_ready`  out  1  a free bank is available for writing
- `rd_en`  in  1  read strobe
- `rd_addr`  in  ADDR_W  read address within current read bank
- `rd_data`  out  DATA_W  read data
- `rd_valid`  out  1  `rd_data` valid this cycle
- `rd_done`  in  1  release current read bank
- `sample_ready`  out  1  at least one committed bank is readable
- `drop_cnt`  out  16  dropped-write counter (only with `INPUT_BUF_DROP_CNT_EN`)

## Operation
- State: `wr_ptr`, `rd_ptr` (0..NUM_BANKS-1, wrap to 0), `full_cnt` (0..NUM_BANKS).
- `wr_ready = (full_cnt < NUM_BANKS)`; `sample_ready = (full_cnt != 0)`.
- Write accepted when `wr_en && wr_ready && wr_addr < DEPTH`: bank `wr_ptr`, entry `wr_addr` <= `wr_data`.
- `wr_en` with `wr_ready`=0, or `wr_addr >= DEPTH`: dropped, no memory change; `wr_last` on a dropped write still commits if `wr_ready`=1, ignored if `wr_ready`=0.
- Commit (`wr_en && wr_last && wr_ready`): `wr_ptr` advances, `full_cnt`+1.
- Read when `rd_en && sample_ready`: bank `rd_ptr`, entry `rd_addr`; out-of-range address returns 0 with `rd_valid`=1.
- `rd_en` with `sample_ready`=0: no read, `rd_valid`=0, `rd_data` holds.
- Release (`rd_done && sample_ready`): `rd_ptr` advances, `full_cnt`-1. `rd_done` with `sample_ready`=0 ignored.
- `rd_en` and `rd_done` same cycle: read uses pre-release `rd_ptr`.
- Commit and release same cycle: both pointers advance, `full_cnt` unchanged.
- Read and write never target same bank (write bank is never a committed bank); no collision logic.
- Partially written banks are not cleared; unwritten entries hold stale data.

## Timing
- Write: data in RAM at next edge; commit visible on `wr_ready`/`sample_ready` one cycle after the `wr_last` edge.
- Read latency 1: `rd_en` at edge N -> `rd_data`/`rd_valid` after edge N; `rd_valid` high for exactly one cycle per accepted read; back-to-back reads give one result per cycle.
- Reset values: `wr_ptr`=0, `rd_ptr`=0, `full_cnt`=0, `wr_ready`=1, `sample_ready`=0, `rd_data`=0, `rd_valid`=0, `drop_cnt`=0. RAM contents not reset.
- Reset mid-operation: any partial or committed sample discarded; in-flight `rd_valid` cleared immediately.

## Configuration
- `INPUT_BUF_DROP_CNT_EN` defined: `drop_cnt` port present; increments by 1 on every dropped write (`wr_en` with `wr_ready`=0 or out-of-range address), saturates at 0xFFFF, cleared only by `rst`.
- Undefined: no `drop_cnt` port, no counter logic; drops silent.

## Structure
- Package `snn_input_pkg`: default `DATA_W`, `DEPTH`, `NUM_BANKS`, `DROP_CNT_W`=16, pointer typedef.
- Sub-module `input_value_bank`: one simple dual-port RAM (write port, registered read port, 1-cycle latency); instantiated `NUM_BANKS` times, outputs muxed by registered `rd_ptr`.

## Test plan
- Reset, write addr 0..1022 with `data=addr[7:0]`, `wr_last` on 1022 -> `sample_ready`=1; read addr 5 -> `rd_data`=5, `rd_valid` one cycle later.
- Fill bank0, start filling bank1 while reading bank0 -> bank0 reads unaffected; commit bank1 -> `wr_ready`=0, writes dropped (`drop_cnt`=1 per drop when enabled).
- Commit bank1 and `rd_done` bank0 same cycle -> `full_cnt` stays 1, `rd_ptr`=1, `wr_ptr`=0, `wr_ready`=1.
- `rd_en` and `rd_done` same cycle on bank0 -> data from bank0, next read from bank1.
- `rd_en` with `sample_ready`=0 -> `rd_valid`=0, `rd_data` unchanged; write to addr 1023 -> dropped, read addr 1023 -> 0.
- Assert `rst` mid-read with two banks committed -> `sample_ready`=0, `wr_ready`=1, `rd_valid`=0 immediately.
